// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: consumes DIGIT bits of A/B per clock through a
// registered carry, and presents Sum/Carry/Overflow with a one-cycle done pulse.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             Sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry,
  output logic             Overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry_r;
  logic [CW-1:0]    cnt_r;
  logic [DIGIT-1:0] dsum_s;
  logic             dcout_s;
  logic             dcmsb_s;
  logic [WIDTH-1:0] a_nxt_s;
  logic [WIDTH-1:0] b_nxt_s;

  // Returns {carry out, carry into digit MSB, digit sum}.
  function automatic logic [DIGIT+1:0] digit_add(
    input logic [DIGIT-1:0] a,
    input logic [DIGIT-1:0] b,
    input logic             cin
  );
    logic [DIGIT:0] s;
    s = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
    digit_add = {s[DIGIT], s[DIGIT-1] ^ a[DIGIT-1] ^ b[DIGIT-1], s[DIGIT-1:0]};
  endfunction

  // Add the current low digit of both operands with the registered carry.
  always_comb begin
    {dcout_s, dcmsb_s, dsum_s} = digit_add(a_r[DIGIT-1:0], b_r[DIGIT-1:0], carry_r);
  end

  // A's register doubles as the result register: each digit sum enters at the
  // top as the consumed operand digit leaves at the bottom.
  generate
    if (DIGIT < WIDTH) begin : g_shift
      assign a_nxt_s = {dsum_s, a_r[WIDTH-1:DIGIT]};
      assign b_nxt_s = {{DIGIT{1'b0}}, b_r[WIDTH-1:DIGIT]};
    end else begin : g_whole
      assign a_nxt_s = dsum_s;
      assign b_nxt_s = {WIDTH{1'b0}};
    end
  endgenerate

  // Control FSM, operand/carry datapath and registered result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      carry_r  <= 1'b0;
      cnt_r    <= {CW{1'b0}};
      busy     <= 1'b0;
      done     <= 1'b0;
      Sum      <= {WIDTH{1'b0}};
      Carry    <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r     <= A;
            b_r     <= Sub ? ~B : B;
            carry_r <= Sub ? ~Cin : Cin;
            cnt_r   <= {CW{1'b0}};
            busy    <= 1'b1;
            state_r <= RUN;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          a_r     <= a_nxt_s;
          b_r     <= b_nxt_s;
          carry_r <= dcout_s;
          cnt_r   <= cnt_r + CW'(1);
          if (cnt_r == LAST) begin
            Sum      <= a_nxt_s;
            Carry    <= dcout_s;
            Overflow <= dcmsb_s ^ dcout_s;
            busy     <= 1'b0;
            done     <= 1'b1;
            state_r  <= IDLE;
          end else begin
            state_r <= RUN;
          end
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed and exhaustive checks of serial_adder across several WIDTH/DIGIT configurations.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // 8-bit instances share operands, each has its own start
  logic [7:0] a8 = 8'h00, b8 = 8'h00;
  logic sub8 = 1'b0, cin8 = 1'b0;
  logic s81 = 1'b0, s84 = 1'b0, s88 = 1'b0;
  logic bz81, dn81, cy81, ov81, bz84, dn84, cy84, ov84, bz88, dn88, cy88, ov88;
  logic [7:0] sm81, sm84, sm88;

  // 4-bit instances (DIGIT 1, 2, 4) run in lockstep on the same inputs
  logic [3:0] a4 = 4'h0, b4 = 4'h0;
  logic sub4 = 1'b0, cin4 = 1'b0, st4 = 1'b0;
  logic [2:0] bz4, dn4, cy4, ov4;
  logic [3:0] sm4 [3];

  serial_adder #(.WIDTH(8), .DIGIT(1)) u8_1 (.clk(clk), .rst(rst), .start(s81), .Sub(sub8), .A(a8), .B(b8),
    .Cin(cin8), .busy(bz81), .done(dn81), .Sum(sm81), .Carry(cy81), .Overflow(ov81));
  serial_adder #(.WIDTH(8), .DIGIT(4)) u8_4 (.clk(clk), .rst(rst), .start(s84), .Sub(sub8), .A(a8), .B(b8),
    .Cin(cin8), .busy(bz84), .done(dn84), .Sum(sm84), .Carry(cy84), .Overflow(ov84));
  serial_adder #(.WIDTH(8), .DIGIT(8)) u8_8 (.clk(clk), .rst(rst), .start(s88), .Sub(sub8), .A(a8), .B(b8),
    .Cin(cin8), .busy(bz88), .done(dn88), .Sum(sm88), .Carry(cy88), .Overflow(ov88));
  serial_adder #(.WIDTH(4), .DIGIT(1)) u4_1 (.clk(clk), .rst(rst), .start(st4), .Sub(sub4), .A(a4), .B(b4),
    .Cin(cin4), .busy(bz4[0]), .done(dn4[0]), .Sum(sm4[0]), .Carry(cy4[0]), .Overflow(ov4[0]));
  serial_adder #(.WIDTH(4), .DIGIT(2)) u4_2 (.clk(clk), .rst(rst), .start(st4), .Sub(sub4), .A(a4), .B(b4),
    .Cin(cin4), .busy(bz4[1]), .done(dn4[1]), .Sum(sm4[1]), .Carry(cy4[1]), .Overflow(ov4[1]));
  serial_adder #(.WIDTH(4), .DIGIT(4)) u4_4 (.clk(clk), .rst(rst), .start(st4), .Sub(sub4), .A(a4), .B(b4),
    .Cin(cin4), .busy(bz4[2]), .done(dn4[2]), .Sum(sm4[2]), .Carry(cy4[2]), .Overflow(ov4[2]));

  // Reference: {Carry, Overflow, Sum} for a 4-bit add/subtract
  function automatic logic [5:0] ref4(input logic [3:0] a, input logic [3:0] b, input logic ci, input logic s);
    logic [3:0] bb;
    logic       cc;
    logic [4:0] full;
    logic [3:0] low;
    bb   = s ? ~b : b;
    cc   = s ? ~ci : ci;
    full = {1'b0, a} + {1'b0, bb} + {4'b0000, cc};
    low  = {1'b0, a[2:0]} + {1'b0, bb[2:0]} + {3'b000, cc};
    return {full[4], low[3] ^ full[4], full[3:0]};
  endfunction

  task automatic test_reset();
    #12;
    checks++;
    if ({bz81, dn81, cy81, ov81, sm81} !== 12'h000) begin
      fails++; $display("FAIL reset_u8_1: got %h expected %h", {bz81, dn81, cy81, ov81, sm81}, 12'h000);
    end
    checks++;
    if ({bz88, dn88, cy88, ov88, sm88, bz84, dn84} !== 14'h0000) begin
      fails++; $display("FAIL reset_u8_8: got %h expected %h", {bz88, dn88, cy88, ov88, sm88, bz84, dn84}, 14'h0000);
    end
    checks++;
    if ({bz4, dn4, cy4, ov4} !== 12'h000) begin
      fails++; $display("FAIL reset_u4: got %h expected %h", {bz4, dn4, cy4, ov4}, 12'h000);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add_d1();
    a8 = 8'hFF; b8 = 8'h01; sub8 = 1'b0; cin8 = 1'b0; s81 = 1'b1;
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      if (k == 0) s81 = 1'b0;
      checks++;
      if (bz81 !== (k < 8)) begin
        fails++; $display("FAIL add_busy k=%0d: got %b expected %b", k, bz81, (k < 8));
      end
      checks++;
      if (dn81 !== (k == 8)) begin
        fails++; $display("FAIL add_done k=%0d: got %b expected %b", k, dn81, (k == 8));
      end
    end
    checks++;
    if ({cy81, ov81, sm81} !== {1'b1, 1'b0, 8'h00}) begin
      fails++; $display("FAIL add_ff_01: got %h expected %h", {cy81, ov81, sm81}, {1'b1, 1'b0, 8'h00});
    end
  endtask

  task automatic test_vectors_d1();
    logic [7:0] va [3];
    logic [7:0] vb [3];
    logic       vs [3];
    logic [9:0] ve [3];
    va = '{8'h7F, 8'h05, 8'h80};
    vb = '{8'h01, 8'h07, 8'h01};
    vs = '{1'b0, 1'b1, 1'b1};
    ve = '{{1'b0, 1'b1, 8'h80}, {1'b0, 1'b0, 8'hFE}, {1'b1, 1'b1, 8'h7F}};
    for (int i = 0; i < 3; i++) begin
      a8 = va[i]; b8 = vb[i]; sub8 = vs[i]; cin8 = 1'b0; s81 = 1'b1;
      for (int k = 0; k <= 8; k++) begin
        @(negedge clk);
        if (k == 0) s81 = 1'b0;
      end
      checks++;
      if ({dn81, cy81, ov81, sm81} !== {1'b1, ve[i]}) begin
        fails++; $display("FAIL vector_%0d: got %h expected %h", i, {dn81, cy81, ov81, sm81}, {1'b1, ve[i]});
      end
    end
    sub8 = 1'b0;
  endtask

  task automatic test_digit4();
    a8 = 8'h3C; b8 = 8'hC4; sub8 = 1'b0; cin8 = 1'b1; s84 = 1'b1;
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      if (k == 0) s84 = 1'b0;
      checks++;
      if (dn84 !== (k == 2)) begin
        fails++; $display("FAIL d4_done k=%0d: got %b expected %b", k, dn84, (k == 2));
      end
    end
    checks++;
    if ({cy84, ov84, sm84} !== {1'b1, 1'b0, 8'h01}) begin
      fails++; $display("FAIL d4_result: got %h expected %h", {cy84, ov84, sm84}, {1'b1, 1'b0, 8'h01});
    end
    cin8 = 1'b0;
  endtask

  // start held high on the single-digit instance: the completing edge is still
  // in RUN, so the follow-on start is taken on the next edge (done 1 cycle apart).
  task automatic test_digit8_b2b();
    a8 = 8'h12; b8 = 8'h34; s88 = 1'b1;
    @(negedge clk);
    checks++;
    if ({bz88, dn88} !== 2'b10) begin
      fails++; $display("FAIL d8_run: got %b expected %b", {bz88, dn88}, 2'b10);
    end
    a8 = 8'hF0; b8 = 8'h0F;
    @(negedge clk);
    checks++;
    if ({dn88, cy88, ov88, sm88} !== {1'b1, 1'b0, 1'b0, 8'h46}) begin
      fails++; $display("FAIL d8_first: got %h expected %h", {dn88, cy88, ov88, sm88}, {1'b1, 1'b0, 1'b0, 8'h46});
    end
    @(negedge clk);
    s88 = 1'b0;
    checks++;
    if ({bz88, dn88} !== 2'b10) begin
      fails++; $display("FAIL d8_second_run: got %b expected %b", {bz88, dn88}, 2'b10);
    end
    @(negedge clk);
    checks++;
    if ({dn88, cy88, ov88, sm88} !== {1'b1, 1'b0, 1'b0, 8'hFF}) begin
      fails++; $display("FAIL d8_second: got %h expected %h", {dn88, cy88, ov88, sm88}, {1'b1, 1'b0, 1'b0, 8'hFF});
    end
  endtask

  task automatic test_ignore_start();
    a8 = 8'h11; b8 = 8'h22; sub8 = 1'b0; cin8 = 1'b0; s81 = 1'b1;
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      if (k == 0) s81 = 1'b0;
      if (k == 3) begin
        s81 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; sub8 = 1'b1; cin8 = 1'b1;
      end
      if (k == 4) s81 = 1'b0;
      if (k == 8) begin
        checks++;
        if ({dn81, cy81, ov81, sm81} !== {1'b1, 1'b0, 1'b0, 8'h33}) begin
          fails++; $display("FAIL ignore_result: got %h expected %h", {dn81, cy81, ov81, sm81}, {1'b1, 1'b0, 1'b0, 8'h33});
        end
      end
    end
    checks++;
    if ({bz81, dn81, sm81} !== {1'b0, 1'b0, 8'h33}) begin
      fails++; $display("FAIL ignore_not_queued: got %h expected %h", {bz81, dn81, sm81}, {1'b0, 1'b0, 8'h33});
    end
    sub8 = 1'b0; cin8 = 1'b0;
  endtask

  task automatic test_back_to_back();
    a8 = 8'h10; b8 = 8'h20; s81 = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      if (k == 0) s81 = 1'b0;
    end
    checks++;
    if ({dn81, sm81} !== {1'b1, 8'h30}) begin
      fails++; $display("FAIL b2b_first: got %h expected %h", {dn81, sm81}, {1'b1, 8'h30});
    end
    a8 = 8'h01; b8 = 8'h02; s81 = 1'b1;
    for (int j = 0; j <= 8; j++) begin
      @(negedge clk);
      if (j == 0) s81 = 1'b0;
      if (j < 8) begin
        checks++;
        if ({bz81, dn81, sm81} !== {1'b1, 1'b0, 8'h30}) begin
          fails++; $display("FAIL b2b_hold j=%0d: got %h expected %h", j, {bz81, dn81, sm81}, {1'b1, 1'b0, 8'h30});
        end
      end
    end
    checks++;
    if ({bz81, dn81, cy81, ov81, sm81} !== {1'b0, 1'b1, 1'b0, 1'b0, 8'h03}) begin
      fails++; $display("FAIL b2b_second: got %h expected %h", {bz81, dn81, cy81, ov81, sm81}, {4'b0100, 8'h03});
    end
  endtask

  task automatic test_reset_midop();
    a8 = 8'h7F; b8 = 8'h01; s81 = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      if (k == 0) s81 = 1'b0;
    end
    checks++;
    if ({cy81, ov81, sm81} !== {1'b0, 1'b1, 8'h80}) begin
      fails++; $display("FAIL rst_pre: got %h expected %h", {cy81, ov81, sm81}, {1'b0, 1'b1, 8'h80});
    end
    a8 = 8'h5A; b8 = 8'h3C; s81 = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      if (k == 0) s81 = 1'b0;
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({bz81, dn81, cy81, ov81, sm81} !== 12'h000) begin
      fails++; $display("FAIL rst_async: got %h expected %h", {bz81, dn81, cy81, ov81, sm81}, 12'h000);
    end
    for (int k = 0; k < 2; k++) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if ({bz81, dn81} !== 2'b00) begin
        fails++; $display("FAIL rst_no_done k=%0d: got %b expected %b", k, {bz81, dn81}, 2'b00);
      end
    end
    s81 = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      if (k == 0) s81 = 1'b0;
    end
    checks++;
    if ({dn81, cy81, ov81, sm81} !== {1'b1, 1'b0, 1'b1, 8'h96}) begin
      fails++; $display("FAIL rst_fresh: got %h expected %h", {dn81, cy81, ov81, sm81}, {1'b1, 1'b0, 1'b1, 8'h96});
    end
  endtask

  task automatic test_exhaustive4();
    int         lat [3];
    logic [5:0] exp6;
    lat = '{4, 2, 1};
    for (int s = 0; s < 2; s++)
      for (int ci = 0; ci < 2; ci++)
        for (int a = 0; a < 16; a++)
          for (int b = 0; b < 16; b++) begin
            a4 = 4'(a); b4 = 4'(b); cin4 = 1'(ci); sub4 = 1'(s); st4 = 1'b1;
            exp6 = ref4(4'(a), 4'(b), 1'(ci), 1'(s));
            @(negedge clk);
            st4 = 1'b0;
            for (int k = 1; k <= 4; k++) begin
              @(negedge clk);
              for (int i = 0; i < 3; i++) begin
                checks++;
                if (dn4[i] !== (k == lat[i])) begin
                  fails++; $display("FAIL ex_latency i=%0d a=%h b=%h k=%0d: got %b expected %b", i, a, b, k, dn4[i], (k == lat[i]));
                end
                if (k == lat[i]) begin
                  checks++;
                  if ({cy4[i], ov4[i], sm4[i]} !== exp6) begin
                    fails++; $display("FAIL ex_result i=%0d s=%0d ci=%0d a=%h b=%h: got %h expected %h", i, s, ci, a, b, {cy4[i], ov4[i], sm4[i]}, exp6);
                  end
                end
              end
            end
          end
  endtask

  initial begin
    test_reset();
    test_add_d1();
    test_vectors_d1();
    test_digit4();
    test_digit8_b2b();
    test_ignore_start();
    test_back_to_back();
    test_reset_midop();
    test_exhaustive4();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
